// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Sequencing FSM for a multi-cycle RV32I datapath (load, store,
//               addi, R-type). BEQ support is compiled in with the macro
//               MULTICYCLE_CTRL_BRANCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       reg_we,
    output logic       wb_sel,
    output logic [1:0] err_code,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_ADDI   = 7'b0010011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
`ifdef MULTICYCLE_CTRL_BRANCH_EN
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
`endif

    localparam logic [1:0] c_ERR_NONE    = 2'b00;
    localparam logic [1:0] c_ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;

    localparam logic [1:0] c_ALU_ADD    = 2'b00;
    localparam logic [1:0] c_ALU_SUB    = 2'b01;
    localparam logic [1:0] c_ALU_FUNCT  = 2'b10;

    localparam logic [7:0] c_TIMEOUT    = 8'(MEM_TIMEOUT);
    localparam logic       c_TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t     r_state_q;
    state_t     w_state_d;
    logic [1:0] r_err_q;
    logic [1:0] w_err_d;
    logic [7:0] r_wait_q;
    logic [7:0] w_wait_d;

    logic w_is_load;
    logic w_is_store;
    logic w_is_addi;
    logic w_is_rtype;
    logic w_is_beq;
    logic w_legal;
    logic w_timeout;

    // Opcode decode; only consulted from DECODE onward, so FETCH-time
    // changes on the opcode input have no effect.
    always_comb begin
        w_is_load  = (opcode == c_OP_LOAD);
        w_is_store = (opcode == c_OP_STORE);
        w_is_addi  = (opcode == c_OP_ADDI);
        w_is_rtype = (opcode == c_OP_RTYPE);
`ifdef MULTICYCLE_CTRL_BRANCH_EN
        w_is_beq   = (opcode == c_OP_BRANCH);
`else
        w_is_beq   = 1'b0;
`endif
        w_legal    = w_is_load | w_is_store | w_is_addi | w_is_rtype | w_is_beq;
    end

`ifndef MULTICYCLE_CTRL_BRANCH_EN
    logic w_unused_zero;
    assign w_unused_zero = zero;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= S_FETCH;
            r_err_q   <= c_ERR_NONE;
            r_wait_q  <= 8'd0;
        end else begin
            r_state_q <= w_state_d;
            r_err_q   <= w_err_d;
            r_wait_q  <= w_wait_d;
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_err_d      = r_err_q;
        w_wait_d     = r_wait_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        alu_src      = 1'b0;
        alu_op       = c_ALU_ADD;
        reg_we       = 1'b0;
        wb_sel       = 1'b0;

        // A completing transfer on the timeout cycle takes priority.
        w_timeout = c_TIMEOUT_EN && !mem_ready && (r_wait_q == c_TIMEOUT);

        case (r_state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    w_state_d = S_DECODE;
                end else if (w_timeout) begin
                    w_state_d = S_HALT;
                    w_err_d   = c_ERR_TIMEOUT;
                end
            end

            S_DECODE: begin
                if (w_legal) begin
                    w_state_d = S_EXEC;
                end else begin
                    w_state_d = S_HALT;
                    w_err_d   = c_ERR_ILLEGAL;
                end
            end

            S_EXEC: begin
                if (w_is_rtype) begin
                    alu_op    = c_ALU_FUNCT;
                    w_state_d = S_WB;
                end else if (w_is_addi) begin
                    alu_src   = 1'b1;
                    w_state_d = S_WB;
                end else if (w_is_load || w_is_store) begin
                    alu_src   = 1'b1;
                    w_state_d = S_MEM;
                end else if (w_is_beq) begin
                    // Taken branch overwrites the PC still held by the datapath.
                    alu_op    = c_ALU_SUB;
                    pc_we     = zero;
                    pc_src    = zero;
                    w_state_d = S_FETCH;
                end else begin
                    w_state_d = S_HALT;
                    w_err_d   = c_ERR_ILLEGAL;
                end
            end

            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = w_is_store;
                if (mem_ready) begin
                    w_state_d = w_is_store ? S_FETCH : S_WB;
                end else if (w_timeout) begin
                    w_state_d = S_HALT;
                    w_err_d   = c_ERR_TIMEOUT;
                end
            end

            S_WB: begin
                reg_we    = 1'b1;
                wb_sel    = w_is_load;
                w_state_d = S_FETCH;
            end

            S_HALT: begin
                w_state_d = S_HALT;
            end

            default: begin
                w_state_d = S_HALT;
            end
        endcase

        if ((w_state_d != r_state_q) || mem_ready) begin
            w_wait_d = 8'd0;
        end else if ((r_state_q == S_FETCH) || (r_state_q == S_MEM)) begin
            w_wait_d = r_wait_q + 8'd1;
        end

        // Outputs are held low for the whole reset assertion, dropping any
        // in-flight request immediately.
        if (reset) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            pc_we        = 1'b0;
            pc_src       = 1'b0;
            alu_src      = 1'b0;
            alu_op       = c_ALU_ADD;
            reg_we       = 1'b0;
            wb_sel       = 1'b0;
        end
    end

    assign err_code  = r_err_q;
    assign state_dbg = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed-vector bench for multicycle_ctrl (MEM_TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_GARB  = 7'b1111111;

    localparam logic [1:0] E0  = 2'b00;
    localparam logic [1:0] EIL = 2'b01;
    localparam logic [1:0] ETO = 2'b10;

    // {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src, alu_op, reg_we, wb_sel}
    localparam logic [10:0] O_NONE       = 11'b0_0_0_0_0_0_0_00_0_0;
    localparam logic [10:0] O_FETCH_WAIT = 11'b1_0_0_0_0_0_0_00_0_0;
    localparam logic [10:0] O_FETCH_DONE = 11'b1_0_0_1_1_0_0_00_0_0;
    localparam logic [10:0] O_EXEC_I     = 11'b0_0_0_0_0_0_1_00_0_0;
    localparam logic [10:0] O_EXEC_R     = 11'b0_0_0_0_0_0_0_10_0_0;
    localparam logic [10:0] O_MEM_LD     = 11'b1_0_1_0_0_0_0_00_0_0;
    localparam logic [10:0] O_MEM_ST     = 11'b1_1_1_0_0_0_0_00_0_0;
    localparam logic [10:0] O_WB_ALU     = 11'b0_0_0_0_0_0_0_00_1_0;
    localparam logic [10:0] O_WB_LD      = 11'b0_0_0_0_0_0_0_00_1_1;
    localparam logic [10:0] O_BEQ_T      = 11'b0_0_0_0_1_1_0_01_0_0;
    localparam logic [10:0] O_BEQ_N      = 11'b0_0_0_0_0_0_0_01_0_0;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src;
    logic       alu_src, reg_we, wb_sel;
    logic [1:0] alu_op, err_code;
    logic [2:0] state_dbg;
    logic [15:0] obs;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .err_code     (err_code),
        .state_dbg    (state_dbg)
    );

    assign obs = {state_dbg, err_code, mem_req, mem_we, mem_addr_sel, ir_we,
                  pc_we, pc_src, alu_src, alu_op, reg_we, wb_sel};

    // Inputs change just after the falling edge; outputs are sampled 2ns later.
    task automatic step(input logic [6:0] o, input logic r, input logic z);
        @(negedge clk);
        opcode    = o;
        mem_ready = r;
        zero      = z;
        #2;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        if (obs !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_hold obs=%h exp=%h", obs, 16'h0000);
        end
        n_vec++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(OP_ADDI, 1'b0, 1'b0);
        if (obs !== {3'd0, E0, O_FETCH_WAIT}) begin
            n_err++;
            $display("FAIL reset_release obs=%h exp=%h", obs, {3'd0, E0, O_FETCH_WAIT});
        end
        n_vec++;
    endtask

    task automatic test_addi();
        logic [6:0]  op [5] = '{OP_GARB, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
        logic        rd [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [15:0] ex [5] = '{{3'd0, E0, O_FETCH_DONE}, {3'd1, E0, O_NONE},
                                {3'd2, E0, O_EXEC_I}, {3'd4, E0, O_WB_ALU},
                                {3'd0, E0, O_FETCH_WAIT}};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(op[i], rd[i], 1'b0);
            if (obs !== ex[i]) begin
                n_err++;
                $display("FAIL addi cyc%0d obs=%h exp=%h", i, obs, ex[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_rtype();
        logic [6:0]  op [5] = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE};
        logic        rd [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [15:0] ex [5] = '{{3'd0, E0, O_FETCH_DONE}, {3'd1, E0, O_NONE},
                                {3'd2, E0, O_EXEC_R}, {3'd4, E0, O_WB_ALU},
                                {3'd0, E0, O_FETCH_WAIT}};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(op[i], rd[i], 1'b0);
            if (obs !== ex[i]) begin
                n_err++;
                $display("FAIL rtype cyc%0d obs=%h exp=%h", i, obs, ex[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_load_wait();
        logic        rd [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] ex [9] = '{{3'd0, E0, O_FETCH_DONE}, {3'd1, E0, O_NONE},
                                {3'd2, E0, O_EXEC_I}, {3'd3, E0, O_MEM_LD},
                                {3'd3, E0, O_MEM_LD}, {3'd3, E0, O_MEM_LD},
                                {3'd3, E0, O_MEM_LD}, {3'd4, E0, O_WB_LD},
                                {3'd0, E0, O_FETCH_WAIT}};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            step(OP_LOAD, rd[i], 1'b0);
            if (obs !== ex[i]) begin
                n_err++;
                $display("FAIL load cyc%0d obs=%h exp=%h", i, obs, ex[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_store();
        logic        rd [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] ex [10] = '{{3'd0, E0, O_FETCH_WAIT}, {3'd0, E0, O_FETCH_WAIT},
                                 {3'd0, E0, O_FETCH_DONE}, {3'd1, E0, O_NONE},
                                 {3'd2, E0, O_EXEC_I}, {3'd3, E0, O_MEM_ST},
                                 {3'd3, E0, O_MEM_ST}, {3'd3, E0, O_MEM_ST},
                                 {3'd0, E0, O_FETCH_WAIT}, {3'd0, E0, O_FETCH_WAIT}};
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            step(OP_STORE, rd[i], 1'b0);
            if (obs !== ex[i]) begin
                n_err++;
                $display("FAIL store cyc%0d obs=%h exp=%h", i, obs, ex[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  op [10] = '{OP_GARB, OP_ADDI, OP_ADDI, OP_ADDI, OP_GARB,
                                 OP_LOAD, OP_LOAD, OP_LOAD, OP_LOAD, OP_LOAD};
        logic        rd [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] ex [10] = '{{3'd0, E0, O_FETCH_DONE}, {3'd1, E0, O_NONE},
                                 {3'd2, E0, O_EXEC_I}, {3'd4, E0, O_WB_ALU},
                                 {3'd0, E0, O_FETCH_DONE}, {3'd1, E0, O_NONE},
                                 {3'd2, E0, O_EXEC_I}, {3'd3, E0, O_MEM_LD},
                                 {3'd4, E0, O_WB_LD}, {3'd0, E0, O_FETCH_WAIT}};
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            step(op[i], rd[i], 1'b0);
            if (obs !== ex[i]) begin
                n_err++;
                $display("FAIL b2b cyc%0d obs=%h exp=%h", i, obs, ex[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        step(OP_GARB, 1'b1, 1'b0);
        if (obs !== {3'd0, E0, O_FETCH_DONE}) begin
            n_err++;
            $display("FAIL illegal_fetch obs=%h exp=%h", obs, {3'd0, E0, O_FETCH_DONE});
        end
        n_vec++;
        step(OP_GARB, 1'b0, 1'b0);
        if (obs !== {3'd1, E0, O_NONE}) begin
            n_err++;
            $display("FAIL illegal_decode obs=%h exp=%h", obs, {3'd1, E0, O_NONE});
        end
        n_vec++;
        for (int i = 0; i < 20; i++) begin
            step(OP_ADDI, 1'b1, i[0]);
            if (obs !== {3'd7, EIL, O_NONE}) begin
                n_err++;
                $display("FAIL illegal_halt cyc%0d obs=%h exp=%h", i, obs, {3'd7, EIL, O_NONE});
            end
            n_vec++;
        end
        #1;
        reset = 1'b1;
        #1;
        if (obs !== 16'h0000) begin
            n_err++;
            $display("FAIL illegal_reset obs=%h exp=%h", obs, 16'h0000);
        end
        n_vec++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(OP_ADDI, 1'b0, 1'b0);
        if (obs !== {3'd0, E0, O_FETCH_WAIT}) begin
            n_err++;
            $display("FAIL illegal_recover obs=%h exp=%h", obs, {3'd0, E0, O_FETCH_WAIT});
        end
        n_vec++;
    endtask

    task automatic test_fetch_timeout();
        logic [15:0] ex [8] = '{{3'd0, E0, O_FETCH_WAIT}, {3'd0, E0, O_FETCH_WAIT},
                                {3'd0, E0, O_FETCH_WAIT}, {3'd0, E0, O_FETCH_WAIT},
                                {3'd0, E0, O_FETCH_WAIT}, {3'd7, ETO, O_NONE},
                                {3'd7, ETO, O_NONE}, {3'd7, ETO, O_NONE}};
        logic        rd [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            step(OP_ADDI, rd[i], 1'b0);
            if (obs !== ex[i]) begin
                n_err++;
                $display("FAIL fetch_timeout cyc%0d obs=%h exp=%h", i, obs, ex[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_timeout_boundary();
        logic        rd [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] ex [6] = '{{3'd0, E0, O_FETCH_WAIT}, {3'd0, E0, O_FETCH_WAIT},
                                {3'd0, E0, O_FETCH_WAIT}, {3'd0, E0, O_FETCH_WAIT},
                                {3'd0, E0, O_FETCH_DONE}, {3'd1, E0, O_NONE}};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(OP_ADDI, rd[i], 1'b0);
            if (obs !== ex[i]) begin
                n_err++;
                $display("FAIL timeout_edge cyc%0d obs=%h exp=%h", i, obs, ex[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_mem_timeout();
        logic        rd [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [15:0] ex [9] = '{{3'd0, E0, O_FETCH_DONE}, {3'd1, E0, O_NONE},
                                {3'd2, E0, O_EXEC_I}, {3'd3, E0, O_MEM_LD},
                                {3'd3, E0, O_MEM_LD}, {3'd3, E0, O_MEM_LD},
                                {3'd3, E0, O_MEM_LD}, {3'd3, E0, O_MEM_LD},
                                {3'd7, ETO, O_NONE}};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            step(OP_LOAD, rd[i], 1'b0);
            if (obs !== ex[i]) begin
                n_err++;
                $display("FAIL mem_timeout cyc%0d obs=%h exp=%h", i, obs, ex[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_reset_mid_request();
        apply_reset();
        step(OP_STORE, 1'b1, 1'b0);
        step(OP_STORE, 1'b0, 1'b0);
        step(OP_STORE, 1'b0, 1'b0);
        step(OP_STORE, 1'b0, 1'b0);
        if (obs !== {3'd3, E0, O_MEM_ST}) begin
            n_err++;
            $display("FAIL midreq_mem obs=%h exp=%h", obs, {3'd3, E0, O_MEM_ST});
        end
        n_vec++;
        #1;
        reset = 1'b1;
        #1;
        if (obs !== 16'h0000) begin
            n_err++;
            $display("FAIL midreq_drop obs=%h exp=%h", obs, 16'h0000);
        end
        n_vec++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(OP_STORE, 1'b0, 1'b0);
        if (obs !== {3'd0, E0, O_FETCH_WAIT}) begin
            n_err++;
            $display("FAIL midreq_refetch obs=%h exp=%h", obs, {3'd0, E0, O_FETCH_WAIT});
        end
        n_vec++;
    endtask

    task automatic test_branch();
`ifdef MULTICYCLE_CTRL_BRANCH_EN
        logic        rd [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        zr [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] ex [8] = '{{3'd0, E0, O_FETCH_DONE}, {3'd1, E0, O_NONE},
                                {3'd2, E0, O_BEQ_T}, {3'd0, E0, O_FETCH_WAIT},
                                {3'd0, E0, O_FETCH_DONE}, {3'd1, E0, O_NONE},
                                {3'd2, E0, O_BEQ_N}, {3'd0, E0, O_FETCH_WAIT}};
`else
        logic        rd [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        zr [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [15:0] ex [8] = '{{3'd0, E0, O_FETCH_DONE}, {3'd1, E0, O_NONE},
                                {3'd7, EIL, O_NONE}, {3'd7, EIL, O_NONE},
                                {3'd7, EIL, O_NONE}, {3'd7, EIL, O_NONE},
                                {3'd7, EIL, O_NONE}, {3'd7, EIL, O_NONE}};
`endif
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            step(OP_BEQ, rd[i], zr[i]);
            if (obs !== ex[i]) begin
                n_err++;
                $display("FAIL beq cyc%0d obs=%h exp=%h", i, obs, ex[i]);
            end
            n_vec++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = OP_ADDI;
        zero      = 1'b0;
        mem_ready = 1'b1;
        test_reset();
        test_addi();
        test_rtype();
        test_load_wait();
        test_store();
        test_back_to_back();
        test_illegal();
        test_fetch_timeout();
        test_timeout_boundary();
        test_mem_timeout();
        test_reset_mid_request();
        test_branch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy FSM that sequences the multi-cycle RV32I datapath: instruction register, PC, register file, ALU, immediate generator and the shared unified memory.
- Decodes the opcode held in the instruction register and drives per-state enables and muxes.
- Handles a ready handshake on the memory port, with an optional stall timeout.
- Supports loads, stores, addi (I-type ALU) and R-type; BEQ is available only when the optional feature is compiled in.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive wait cycles (mem_req=1, mem_ready=0) before a fault; 0 disables the timeout; legal range 0..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  inst[6:0] from the instruction register; stable from DECODE onward.
- zero  in  1  ALU zero flag; used only for BEQ.
- mem_ready  in  1  memory has completed the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  load the instruction register from memory read data.
- pc_we  out  1  PC write enable.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- alu_src  out  1  0 = rs2, 1 = sign-extended immediate.
- alu_op  out  2  00 add, 01 sub, 10 decode from funct3/funct7.
- reg_we  out  1  register file write enable.
- wb_sel  out  1  0 = ALU result, 1 = memory read data.
- err_code  out  2  00 none, 01 illegal opcode, 10 memory timeout; sticky.
- state_dbg  out  3  current state encoding.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- Reset (asynchronous): state=FETCH, wait counter=0, err_code=00.
  - All outputs default to 0 in every state unless listed below; this includes the reset state.
  - Reset mid-request drops mem_req immediately. No partial write is re-issued.
- FETCH: mem_req=1, mem_addr_sel=0.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=0 in that same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle.
  - Legal opcodes (0000011, 0100011, 0010011, 0110011; plus 1100011 when the macro is defined) -> EXEC.
  - Any other opcode -> HALT with err_code=01.
- EXEC: one cycle.
  - Load, store, addi: alu_src=1, alu_op=00. R-type: alu_src=0, alu_op=10.
  - Next state: load/store -> MEM; addi/R-type -> WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for stores only.
  - On mem_ready: store -> FETCH; load -> WB.
  - mem_we must not toggle while waiting.
- WB: one cycle. reg_we=1; wb_sel=1 for loads, 0 otherwise. Next state is FETCH.
- HALT: all enables 0. Exit only via reset.
- Wait counter:
  - 8-bit. Increments each cycle in FETCH or MEM while mem_ready=0.
  - Clears on mem_ready and on any state change.
  - When MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT with mem_ready still 0: next state HALT, err_code=10.
  - mem_ready arriving on the timeout cycle wins: the transfer completes and there is no fault.
- Latency with zero memory wait: addi/R-type = 4 cycles; load = 5; store = 4.
- The opcode input is sampled only in DECODE, EXEC, MEM and WB. Changes to it during FETCH are ignored.

Optional Feature:
- Macro: MULTICYCLE_CTRL_BRANCH_EN.
- Defined:
  - Opcode 1100011 (BEQ) is legal.
  - In EXEC: alu_src=0, alu_op=01. If zero=1: pc_we=1, pc_src=1. Next state is FETCH (3 cycles total).
  - The datapath holds the old PC for target computation.
- Undefined:
  - 1100011 is illegal: HALT with err_code=01.
  - The zero input is ignored.

Test Plan:
- Reset, then addi (opcode 0010011), mem_ready=1 in FETCH -> states 0,1,2,4,0; ir_we and pc_we pulse in cycle 1; reg_we=1, wb_sel=0 in cycle 4.
- Load with mem_ready held low 3 cycles in MEM -> MEM lasts 4 cycles with mem_req=1, mem_addr_sel=1, mem_we=0; then WB with wb_sel=1, reg_we=1.
- Store -> MEM with mem_we=1 until mem_ready, then FETCH; reg_we never asserted.
- Opcode 1111111 in DECODE -> HALT, err_code=01, all enables 0 for 20 cycles; reset -> FETCH, err_code=00.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> HALT with err_code=10 after 5 cycles in FETCH. Repeat with mem_ready=1 on the 5th cycle -> DECODE, no fault.
- BEQ with zero=1 (macro defined) -> EXEC asserts pc_we=1, pc_src=1, alu_op=01, then FETCH. Macro undefined -> HALT, err_code=01.
